// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int unsigned STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/data_mem_arbiter.sv
// Single-port data RAM arbiter: pipeline MEM stage vs. debug read port, with
// starvation guard for debug and read-return routing by owner tracking.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   p_req,
  input  logic                   p_we,
  input  logic [AW-1:0]          p_addr,
  input  logic [DW-1:0]          p_wdata,
  output logic                   p_stall,
  output logic                   p_rvalid,
  output logic [DW-1:0]          p_rdata,
  input  logic                   d_req,
  input  logic [AW-1:0]          d_addr,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [DW-1:0]          d_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic [DW-1:0]          mem_rdata,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

  logic                   grant_p;
  logic                   grant_d;
  logic [3:0]             starve_q, starve_d;
  owner_t                 owner_q, owner_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Debug wins when the pipeline is idle or debug has been denied long enough.
  always_comb begin
    grant_d = d_req & (~p_req | (starve_q == StarveLim));
    grant_p = p_req & ~grant_d;
  end

  always_comb begin
    p_stall = p_req & ~grant_p;
    d_gnt   = grant_d;
    // Keep the RAM quiet while reset is held, regardless of requests.
    mem_en  = (grant_p | grant_d) & ~reset;
    mem_we  = grant_p & p_we & ~reset;
    if (grant_d) begin
      mem_addr  = d_addr;
      mem_wdata = '0;
    end else if (grant_p) begin
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
    end else begin
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_comb begin
    p_rvalid = (owner_q == OWN_P);
    d_rvalid = (owner_q == OWN_D);
    p_rdata  = p_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
    stall_count = stall_cnt_q;
  end

  always_comb begin
    starve_d = starve_q;
    if (grant_d || !d_req) begin
      starve_d = '0;
    end else if (starve_q < StarveLim) begin
      starve_d = starve_q + 4'd1;
    end

    if (grant_d) begin
      owner_d = OWN_D;
    end else if (grant_p && !p_we) begin
      owner_d = OWN_P;
    end else begin
      owner_d = OWN_NONE;
    end

    stall_cnt_d = stall_cnt_q;
    if (p_stall && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Arbitrates the single-port data RAM between the pipeline MEM stage and the debug/UI read port. Issues at most one RAM access per cycle and tracks which requester owns the outstanding read so that returned data is routed correctly. Stalls the pipeline when the debug port wins a cycle. Sits between the EX_MEM pipeline register / `ui_handler` debug path and `data_mem`.

## Interface
- `DW`, 32: data width.
- `AW`, 32: address width (byte address, as produced by EX).
- `STARVE_MAX`, 3: consecutive denied debug cycles before debug is forced through; range 1..15.

- `clock` in 1: system clock; RAM samples on the same edge.
- `reset` in 1: asynchronous, active-high.
- `p_req` in 1: pipeline MEM-stage access request, this cycle only.
- `p_we` in 1: pipeline write (1) / read (0).
- `p_addr` in AW: pipeline address.
- `p_wdata` in DW: pipeline write data.
- `p_stall` out 1: pipeline request not served this cycle; hold all stage registers.
- `p_rvalid` out 1: `p_rdata` valid (cycle after grant of a pipeline read).
- `p_rdata` out DW: pipeline read data.
- `d_req` in 1: debug read request, level, held until `d_gnt`.
- `d_addr` in AW: debug address.
- `d_gnt` out 1: debug request accepted this cycle.
- `d_rvalid` out 1: `d_rdata` valid.
- `d_rdata` out DW: debug read data.
- `mem_en` out 1: RAM access this cycle.
- `mem_we` out 1: RAM write strobe.
- `mem_addr` out AW: RAM address.
- `mem_wdata` out DW: RAM write data.
- `mem_rdata` in DW: RAM read data, valid one cycle after a read issue.
- `stall_count` out 16: saturating count of `p_stall` cycles, for UI.

## Operation
- Grant, combinational per cycle:
  - `grant_d = d_req & (~p_req | starve == STARVE_MAX)`.
  - `grant_p = p_req & ~grant_d`.
- `p_stall = p_req & ~grant_p`. `d_gnt = grant_d`. Debug is read-only.
- RAM drive:
  - `mem_en = grant_p | grant_d`.
  - `mem_we = grant_p & p_we`.
  - `mem_addr` and `mem_wdata` are muxed from the granted requester.
  - When idle, `mem_addr` and `mem_wdata` are 0.
- Starvation counter `starve` (4 bits):
  - cleared when `grant_d` or `~d_req`;
  - else incremented, saturating at `STARVE_MAX`.
- Owner FSM tracks the outstanding read: `OWN_NONE`, `OWN_P`, `OWN_D`. Next state each cycle:
  - `OWN_D` if `grant_d`;
  - else `OWN_P` if `grant_p & ~p_we`;
  - else `OWN_NONE`.
  - Pipeline writes never enter `OWN_P`.
- Read return:
  - `p_rvalid = (owner == OWN_P)`, `d_rvalid = (owner == OWN_D)`.
  - `p_rdata` and `d_rdata` each carry `mem_rdata` when their valid is high, else 0.
- `stall_count` increments on every `p_stall` cycle and saturates at 0xFFFF.

## Timing
- Reset, asynchronous: owner = `OWN_NONE`, `starve` = 0, `stall_count` = 0.
  - Therefore `p_rvalid`, `d_rvalid`, `p_rdata` and `d_rdata` are all 0.
  - Combinational outputs follow the inputs during reset, but `mem_en` and `mem_we` are forced to 0 while `reset` is high.
- Read latency is 1 cycle from grant to rvalid. Write completes at the granting edge.
- Back-to-back grants are allowed every cycle, with no bubble between requesters.
- Reset asserted with a read outstanding: the read is discarded and no rvalid is produced after reset.
- Simultaneous pipeline write and debug read to the same address, debug wins (starved): the debug read returns the old value; the pipeline write lands on the next granted cycle.
- Worst-case debug latency is `STARVE_MAX` cycles of denial, then a grant.
- Pipeline stalls at most 1 cycle per debug grant.
- A debug request dropped before grant clears `starve`.

## Structure
- Package `mem_arb_pkg` holds:
  - the `owner_t` enum (`OWN_NONE`, `OWN_P`, `OWN_D`);
  - the `STALL_CNT_W = 16` constant.
- No sub-module. The saturating counters and grant logic are inline.

## Test plan
- Pipeline reads only: `p_req` = 1, `p_we` = 0, addr 0x10, RAM holds 0xDEADBEEF at 0x10 -> `mem_en` = 1 that cycle; next cycle `p_rvalid` = 1, `p_rdata` = 0xDEADBEEF; `p_stall` = 0 throughout.
- Debug idle-path: `p_req` = 0, `d_req` = 1, addr 0x8 -> `d_gnt` = 1 the same cycle; `d_rvalid` = 1 the next cycle with RAM[0x8].
- Starvation, `STARVE_MAX` = 3: `p_req` and `d_req` held high -> pipeline granted 3 cycles, 4th cycle `d_gnt` = 1 and `p_stall` = 1, `stall_count` = 1; pattern repeats every 4 cycles.
- Write then debug read: pipeline write 0x1234 to 0x20 in cycle n, debug read 0x20 in cycle n+1 -> `d_rdata` = 0x1234 at n+2.
- Reset mid-read: pipeline read granted, `reset` pulsed before the next edge -> `p_rvalid` stays 0; owner = `OWN_NONE`; `stall_count` = 0.
- Saturation: force 70000 stall cycles -> `stall_count` holds at 0xFFFF.
